// File: rtl/read_control.sv
// read_control: async-FIFO read side (pointers, Gray sync of wptr, empty/level/underflow); READ_CONTROL_ALMOST_EMPTY_EN adds raempty
module read_control #(
  parameter int ADDR_WIDTH = 9,
  parameter int SYNC_STAGES = 2
`ifdef READ_CONTROL_ALMOST_EMPTY_EN
  , parameter int AE_THRESH = 4
`endif
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  rinc,
  input  logic [ADDR_WIDTH-1:0] wptr_gray,
  output logic                  rempty,
  output logic [ADDR_WIDTH-1:0] rptr_gray,
  output logic [ADDR_WIDTH-2:0] raddr,
  output logic [ADDR_WIDTH-1:0] rlevel,
  output logic                  rerr
`ifdef READ_CONTROL_ALMOST_EMPTY_EN
  , output logic                raempty
`endif
);
  logic [SYNC_STAGES-1:0][ADDR_WIDTH-1:0] sync_q;
  logic [ADDR_WIDTH-1:0] rbin, rbin_next, rgray_next, wsync, wbin, rlevel_next;
  logic pop;
  assign pop = rinc && !rempty;
  assign rbin_next = rbin + ADDR_WIDTH'(pop);
  assign rgray_next = (rbin_next >> 1) ^ rbin_next;
  assign wsync = sync_q[SYNC_STAGES-1];
  assign rlevel_next = wbin - rbin_next;
  assign raddr = rbin[ADDR_WIDTH-2:0];
  always_comb begin
    wbin = '0;
    for (int i = 0; i < ADDR_WIDTH; i++) wbin[i] = ^(wsync >> i);
  end
  always_ff @(posedge rclk)
    if (rrst) sync_q <= '0;
    else sync_q <= {sync_q[SYNC_STAGES-2:0], wptr_gray};
  always_ff @(posedge rclk)
    if (rrst) begin
      rbin <= '0;
      rptr_gray <= '0;
      rempty <= 1'b1;
      rlevel <= '0;
      rerr <= 1'b0;
    end else begin
      rbin <= rbin_next;
      rptr_gray <= rgray_next;
      rempty <= rgray_next == wsync;
      rlevel <= rlevel_next;
      rerr <= rerr | (rinc & rempty);
    end
`ifdef READ_CONTROL_ALMOST_EMPTY_EN
  always_ff @(posedge rclk)
    if (rrst) raempty <= 1'b1;
    else raempty <= rlevel_next <= ADDR_WIDTH'(AE_THRESH);
`endif
endmodule
